// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator datapath: default widths and
// the control-field encodings driven by the BIP control unit.
package bip_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 11;

    typedef enum logic [1:0] {
        SEL_A_MEM  = 2'd0,
        SEL_A_IMM  = 2'd1,
        SEL_A_ALU  = 2'd2,
        SEL_A_HOLD = 2'd3
    } sel_a_e;

    typedef enum logic {
        SEL_B_MEM = 1'b0,
        SEL_B_IMM = 1'b1
    } sel_b_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/bip_alu.sv
// Combinational add/subtract unit of the BIP datapath; results wrap modulo
// 2^DATA_WIDTH with no carry or overflow indication.
module bip_alu
    import bip_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_op,
    output logic [DATA_WIDTH-1:0] o_result
);

    // Select add or subtract; the carry out of the top bit is dropped.
    always_comb begin
        o_result = i_a + i_b;
        if (op_e'(i_op) == OP_SUB) begin
            o_result = i_a - i_b;
        end else begin
            o_result = i_a + i_b;
        end
    end

endmodule

// File: rtl/bip_datapath.sv
// BIP accumulator datapath: ACC register, operand sign extension, A/B muxes.
// Optional registered zero/negative flags when BIP_DATAPATH_FLAGS_EN is defined.
module bip_datapath
    import bip_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            SelA,
    input  logic                  SelB,
    input  logic                  WrAcc,
    input  logic                  Op,
    input  logic [ADDR_WIDTH-1:0] operand,
    input  logic [DATA_WIDTH-1:0] in_memory_data,
    output logic [DATA_WIDTH-1:0] out_memory_data,
    output logic [ADDR_WIDTH-1:0] data_address
`ifdef BIP_DATAPATH_FLAGS_EN
    ,
    output logic                  acc_zero,
    output logic                  acc_neg
`endif
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic [DATA_WIDTH-1:0] w_next;

    assign w_ext = {{(DATA_WIDTH-ADDR_WIDTH){operand[ADDR_WIDTH-1]}}, operand};

    // ALU B operand: memory word or sign-extended immediate.
    always_comb begin
        w_b = in_memory_data;
        if (sel_b_e'(SelB) == SEL_B_IMM) begin
            w_b = w_ext;
        end else begin
            w_b = in_memory_data;
        end
    end

    bip_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_a      (r_acc),
        .i_b      (w_b),
        .i_op     (Op),
        .o_result (w_alu_result)
    );

    // Candidate next ACC value; only committed when WrAcc is set.
    always_comb begin
        w_next = r_acc;
        case (sel_a_e'(SelA))
            SEL_A_MEM:  w_next = in_memory_data;
            SEL_A_IMM:  w_next = w_ext;
            SEL_A_ALU:  w_next = w_alu_result;
            SEL_A_HOLD: w_next = r_acc;
            default:    w_next = r_acc;
        endcase
    end

    // Accumulator register; reset has priority over a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= {DATA_WIDTH{1'b0}};
        end else if (WrAcc) begin
            r_acc <= w_next;
        end else begin
            r_acc <= r_acc;
        end
    end

`ifdef BIP_DATAPATH_FLAGS_EN
    logic r_acc_zero;
    logic r_acc_neg;

    // Flags are derived from the value being written so they track ACC with no extra lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_zero <= 1'b1;
            r_acc_neg  <= 1'b0;
        end else if (WrAcc) begin
            r_acc_zero <= (w_next == {DATA_WIDTH{1'b0}});
            r_acc_neg  <= w_next[DATA_WIDTH-1];
        end else begin
            r_acc_zero <= r_acc_zero;
            r_acc_neg  <= r_acc_neg;
        end
    end

    assign acc_zero = r_acc_zero;
    assign acc_neg  = r_acc_neg;
`endif

    assign out_memory_data = r_acc;
    assign data_address    = operand;

endmodule

// File: tb/tb_bip_datapath.sv
// Self-checking bench for bip_datapath: directed steps plus random traffic
// compared against an integer-arithmetic accumulator model.
module tb_bip_datapath;

    logic        clk;
    logic        rst;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic        Op;
    logic [10:0] operand;
    logic [15:0] in_memory_data;
    logic [15:0] out_memory_data;
    logic [10:0] data_address;
`ifdef BIP_DATAPATH_FLAGS_EN
    logic        acc_zero;
    logic        acc_neg;
`endif

    int checks   = 0;
    int failures = 0;
    int model_acc = 0;

    bip_datapath dut (
        .clk             (clk),
        .rst             (rst),
        .SelA            (SelA),
        .SelB            (SelB),
        .WrAcc           (WrAcc),
        .Op              (Op),
        .operand         (operand),
        .in_memory_data  (in_memory_data),
        .out_memory_data (out_memory_data),
`ifdef BIP_DATAPATH_FLAGS_EN
        .acc_zero        (acc_zero),
        .acc_neg         (acc_neg),
`endif
        .data_address    (data_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the accumulator as a plain integer, immediates as signed numbers.
    function automatic int wrap16(input int v);
        return ((v % 65536) + 65536) % 65536;
    endfunction

    function automatic int model_next(input int acc, input int sela, input int selb,
                                      input int op, input int opnd, input int mem);
        int imm;
        int b;
        imm = (opnd >= 1024) ? opnd - 2048 : opnd;
        b   = (selb == 1) ? imm : mem;
        if (sela == 0) return mem;
        if (sela == 1) return wrap16(imm);
        if (sela == 2) return wrap16((op == 1) ? acc - b : acc + b);
        return acc;
    endfunction

    task automatic check_state(input string tag);
        check(tag, {16'd0, out_memory_data}, model_acc);
`ifdef BIP_DATAPATH_FLAGS_EN
        check({tag, "_zero"}, {31'd0, acc_zero}, (model_acc == 0) ? 1 : 0);
        check({tag, "_neg"},  {31'd0, acc_neg},  (model_acc >= 32768) ? 1 : 0);
`endif
    endtask

    // One clock step; exp >= 0 additionally pins ACC to a hand-derived value.
    task automatic step(input string tag, input int r, input int sela, input int selb,
                        input int op, input int wr, input int opnd, input int mem,
                        input int exp);
        rst            = r[0];
        SelA           = sela[1:0];
        SelB           = selb[0];
        Op             = op[0];
        WrAcc          = wr[0];
        operand        = opnd[10:0];
        in_memory_data = mem[15:0];
        #1;
        check({tag, "_addr"}, {21'd0, data_address}, opnd);
        @(posedge clk);
        if (r != 0) model_acc = 0;
        else if (wr != 0) model_acc = model_next(model_acc, sela, selb, op, opnd, mem);
        #1;
        check_state(tag);
        if (exp >= 0) check({tag, "_const"}, {16'd0, out_memory_data}, exp);
    endtask

    initial begin
        rst = 1'b0; SelA = 2'd0; SelB = 1'b0; WrAcc = 1'b0; Op = 1'b0;
        operand = 11'd0; in_memory_data = 16'd0;
        @(negedge clk);

        step("reset", 1, 0, 0, 0, 1, 0, 'h1234, 0);
        step("load_mem5", 0, 0, 0, 0, 1, 0, 5, 5);
        step("sub_imm_m6", 0, 2, 1, 1, 1, 'h7FA, 0, 11);
        for (int i = 0; i < 3; i++)
            step("hold_wr0", 0, $urandom_range(3), $urandom_range(1), $urandom_range(1),
                 0, $urandom_range(2047), $urandom_range(65535), 11);
        step("imm_0x400", 0, 1, 0, 0, 1, 'h400, 0, 'hFC00);
        step("imm_0x3ff", 0, 1, 0, 0, 1, 'h3FF, 0, 'h03FF);
        step("load_ffff", 0, 0, 0, 0, 1, 0, 'hFFFF, 'hFFFF);
        step("add_wrap", 0, 2, 0, 0, 1, 0, 2, 1);
        step("sub_wrap", 0, 2, 0, 1, 1, 0, 3, 'hFFFE);
        step("hold_sel3", 0, 3, 1, 1, 1, 'h155, 'h4321, 'hFFFE);

        // Address path is combinational: no clock edge between drive and check.
        operand = 11'h155;
        #1;
        check("addr_comb", {21'd0, data_address}, 'h155);

        // A write request raised and withdrawn between edges must not reach ACC.
        @(negedge clk);
        WrAcc = 1'b1; SelA = 2'd0; in_memory_data = 16'h0BAD;
        #2;
        WrAcc = 1'b0;
        @(posedge clk);
        #1;
        check("mid_cycle_glitch", {16'd0, out_memory_data}, 'hFFFE);

        step("load_8000", 0, 0, 0, 0, 1, 0, 'h8000, 'h8000);
        step("sub_mem_8000", 0, 2, 0, 1, 1, 0, 'h8000, 0);
        step("load_nz", 0, 1, 0, 0, 1, 'h7FF, 0, 'hFFFF);
        step("reset_prio", 1, 2, 1, 0, 1, 5, 7, 0);

        for (int i = 0; i < 300; i++)
            step("random", ($urandom_range(19) == 0) ? 1 : 0, $urandom_range(3),
                 $urandom_range(1), $urandom_range(1), $urandom_range(1),
                 $urandom_range(2047), $urandom_range(65535), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bip_datapath.md
Name: bip_datapath

Overview:
- Accumulator datapath of the BIP (Basic Instruction Processor).
- Holds a single 16-bit accumulator (ACC) and performs add/subtract against data memory or a sign-extended 11-bit immediate.
- Drives the data-memory write data and address.
- Sits between the BIP control unit (which supplies SelA/SelB/WrAcc/Op/operand) and the data memory.

Parameters:
- DATA_WIDTH, 16, width of ACC, the ALU and the memory data buses.
- ADDR_WIDTH, 11, width of the instruction operand field and the data address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- SelA  input  2  ACC source select: 0 = in_memory_data, 1 = sign-extended operand, 2 = ALU result, 3 = hold.
- SelB  input  1  ALU B-operand select: 0 = in_memory_data, 1 = sign-extended operand.
- WrAcc  input  1  ACC write enable.
- Op  input  1  ALU operation: 0 = add (ACC + B), 1 = subtract (ACC - B).
- operand  input  ADDR_WIDTH  instruction operand field (address or immediate).
- in_memory_data  input  DATA_WIDTH  data read from data memory.
- out_memory_data  output  DATA_WIDTH  data to data memory; always equals ACC.
- data_address  output  ADDR_WIDTH  data-memory address; combinational copy of operand.

Behaviour:
- Reset: on a rising clk edge with rst=1, ACC <= 0. out_memory_data therefore reads 0 after the reset edge. rst has priority over WrAcc.
- Sign extension: ext = {replicate operand[ADDR_WIDTH-1] (DATA_WIDTH-ADDR_WIDTH) times, operand}.
- B mux: B = SelB ? ext : in_memory_data (combinational).
- ALU: result = Op ? ACC - B : ACC + B, modulo 2^DATA_WIDTH.
  - Two's-complement wrap-around; no carry or overflow output.
  - Purely combinational.
- A mux (combinational):
  - SelA=0: next = in_memory_data.
  - SelA=1: next = ext.
  - SelA=2: next = ALU result.
  - SelA=3: next = ACC (hold).
- ACC update: on a rising clk edge with rst=0 and WrAcc=1, ACC <= next. With WrAcc=0, ACC holds regardless of SelA/SelB/Op.
- Latency: one clock from control inputs to a visible ACC change. data_address has zero latency.
- out_memory_data is registered (it is ACC) and glitch-free.
- No internal state other than ACC and, when enabled, the flag registers below.
- Control inputs are sampled only at the clock edge; changes between edges have no effect.

Optional Feature:
- Macro: BIP_DATAPATH_FLAGS_EN.
- When defined, add two outputs:
  - acc_zero (1 bit): registered; 1 when ACC == 0.
  - acc_neg (1 bit): registered; ACC[DATA_WIDTH-1].
- Flags update in the same edge as ACC, computed from the new value. Both flags reset to acc_zero=1, acc_neg=0.
- When not defined: ports absent, no flag logic.

Decomposition:
- Package bip_pkg holds:
  - DATA_WIDTH / ADDR_WIDTH defaults.
  - SelA encodings: SEL_A_MEM=0, SEL_A_IMM=1, SEL_A_ALU=2, SEL_A_HOLD=3.
  - SelB encodings: SEL_B_MEM=0, SEL_B_IMM=1.
  - Op encodings: OP_ADD=0, OP_SUB=1.
- One sub-module bip_alu: combinational add/sub, DATA_WIDTH-parameterised.
- Sign extension and muxes stay inline in bip_datapath.

Test Plan:
- Reset: rst=1 for one edge with WrAcc=1, SelA=0, in_memory_data=0x1234 -> ACC/out_memory_data = 0x0000.
- Load memory then subtract immediate:
  - SelA=0, WrAcc=1, in_memory_data=5, one edge -> out_memory_data = 5.
  - Then operand=-6 (0x7FA), SelA=2, SelB=1, Op=1, WrAcc=1, one edge -> out_memory_data = 11 (0x000B).
  - Then WrAcc=0 for several edges -> stays 11.
- Load immediate: operand=0x400, SelA=1, WrAcc=1 -> ACC = 0xFC00. Then operand=0x3FF -> ACC = 0x03FF.
- Add from memory with wrap-around: ACC=0xFFFF, SelA=2, SelB=0, Op=0, in_memory_data=2 -> ACC = 0x0001. Subtract memory 3 from 1 -> ACC = 0xFFFE.
- Hold and address path:
  - SelA=3, WrAcc=1 -> ACC unchanged.
  - data_address tracks operand combinationally (operand=0x155 -> data_address=0x155 in the same cycle, no edge needed).
- BIP_DATAPATH_FLAGS_EN:
  - After reset, acc_zero=1 and acc_neg=0.
  - Load 0x8000 -> acc_zero=0, acc_neg=1.
  - Subtract memory 0x8000 -> acc_zero=1, acc_neg=0.
